// File: rtl/rcc_rst_seq_ctrl_if.sv
// rtl/rcc_rst_seq_ctrl_if.sv - control/status bundle of the RCC reset-release sequencer
interface rcc_rst_seq_ctrl_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 8
);
  logic                      testmode;
  logic                      test_rst_n;
  logic                      glb_req;
  logic [CH_NUM-1:0]         ch_req;
  logic [CH_NUM-1:0]         ch_en;
  logic [CH_NUM*CNT_W-1:0]   dly_cfg;
  logic [CH_NUM-1:0]         flag_clr;
  logic [CH_NUM-1:0]         ch_rst_n;
  logic                      seq_done;
  logic                      busy;
  logic [CH_NUM-1:0]         rst_flag;

  modport master (
    output testmode, test_rst_n, glb_req, ch_req, ch_en, dly_cfg, flag_clr,
    input  ch_rst_n, seq_done, busy, rst_flag
  );

  modport slave (
    input  testmode, test_rst_n, glb_req, ch_req, ch_en, dly_cfg, flag_clr,
    output ch_rst_n, seq_done, busy, rst_flag
  );
endinterface

// File: rtl/rcc_rst_seq_ctrl.sv
// rtl/rcc_rst_seq_ctrl.sv - staggered reset-release sequencer for RCC channel resets
module rcc_rst_seq_ctrl #(
  parameter int CH_NUM    = 4,
  parameter int CNT_W     = 8,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_NUM = 2
) (
  input logic               clk,
  input logic               rst_n,
  rcc_rst_seq_ctrl_if.slave bus
);
  localparam int                IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CH_NUM - 1);
  localparam logic [15:0]       HOLD_LAST = 16'(HOLD_CYC - 1);

  typedef enum logic [1:0] {ST_RST, ST_HOLD, ST_REL, ST_DONE} state_e;

  state_e               state_q;
  logic [STAGE_NUM-1:0] glb_sync_q;
  logic [CH_NUM-1:0]    req_sync_q [STAGE_NUM];
  logic                 glb_s;
  logic [CH_NUM-1:0]    req_s;
  logic [CNT_W-1:0]     dly [CH_NUM];
  logic [CNT_W-1:0]     cnt_q [CH_NUM];
  logic [15:0]          hold_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CH_NUM-1:0]    ch_rst_q;
  logic [CH_NUM-1:0]    rst_flag_q;
  logic                 seq_done_q;
  logic                 busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glb_sync_q <= '0;
      for (int k = 0; k < STAGE_NUM; k++) req_sync_q[k] <= '0;
    end else begin
      glb_sync_q    <= {glb_sync_q[STAGE_NUM-2:0], bus.glb_req};
      req_sync_q[0] <= bus.ch_req;
      for (int k = 1; k < STAGE_NUM; k++) req_sync_q[k] <= req_sync_q[k-1];
    end
  end

  assign glb_s = glb_sync_q[STAGE_NUM-1];
  assign req_s = req_sync_q[STAGE_NUM-1];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_dly
    assign dly[g] = bus.dly_cfg[g*CNT_W +: CNT_W];
  end

  // ">=" rather than "==" so a delay lowered below a running count still releases
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      ch_rst_q   <= '0;
      rst_flag_q <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
    end else begin
      rst_flag_q <= (rst_flag_q & ~bus.flag_clr) | ({CH_NUM{state_q == ST_DONE}} & req_s);
      if (state_q == ST_RST || glb_s) begin
        state_q    <= ST_HOLD;
        hold_cnt_q <= '0;
        idx_q      <= '0;
        ch_rst_q   <= '0;
        seq_done_q <= 1'b0;
        busy_q     <= 1'b1;
        for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q    <= ST_REL;
              hold_cnt_q <= '0;
              idx_q      <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          ST_REL: begin
            if (!bus.ch_en[idx_q] || cnt_q[idx_q] >= dly[idx_q]) begin
              // a channel under local request stays held; DONE releases it later
              if (bus.ch_en[idx_q] && !req_s[idx_q]) ch_rst_q[idx_q] <= 1'b1;
              cnt_q[idx_q] <= '0;
              if (idx_q == LAST_IDX) begin
                state_q    <= ST_DONE;
                seq_done_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
            end
          end
          ST_DONE: begin
            for (int i = 0; i < CH_NUM; i++) begin
              if (req_s[i] || !bus.ch_en[i]) begin
                ch_rst_q[i] <= 1'b0;
                cnt_q[i]    <= '0;
              end else if (!ch_rst_q[i]) begin
                if (cnt_q[i] >= dly[i]) begin
                  ch_rst_q[i] <= 1'b1;
                  cnt_q[i]    <= '0;
                end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_RST;
        endcase
      end
    end
  end

  assign bus.ch_rst_n = bus.testmode ? {CH_NUM{bus.test_rst_n}} : ch_rst_q;
  assign bus.seq_done = seq_done_q;
  assign bus.busy     = busy_q;
  assign bus.rst_flag = rst_flag_q;
endmodule

// File: tb/tb_rcc_rst_seq_ctrl.sv
// tb/tb_rcc_rst_seq_ctrl.sv - directed self-checking bench for rcc_rst_seq_ctrl
module tb_rcc_rst_seq_ctrl;
  localparam int CH_NUM    = 4;
  localparam int CNT_W     = 8;
  localparam int HOLD_CYC  = 4;
  localparam int STAGE_NUM = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // release edge of each channel, counted from E0
  int r_def [4] = '{7, 10, 13, 16};
  int r_dis [4] = '{5, 6, 1000, 8};

  rcc_rst_seq_ctrl_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) bus ();

  rcc_rst_seq_ctrl #(
    .CH_NUM(CH_NUM), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC), .STAGE_NUM(STAGE_NUM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input int k, input int rel [4], input int done_e);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (k >= rel[i]);
    check_eq($sformatf("E%0d ch_rst_n", k), 32'(bus.ch_rst_n), 32'(e));
    check_eq($sformatf("E%0d seq_done", k), 32'(bus.seq_done), 32'(k >= done_e));
    check_eq($sformatf("E%0d busy", k), 32'(bus.busy), 32'(k < done_e));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.testmode   = 1'b0;
    bus.test_rst_n = 1'b0;
    bus.glb_req    = 1'b0;
    bus.ch_req     = '0;
    bus.ch_en      = 4'hF;
    bus.dly_cfg    = {4{8'd2}};
    bus.flag_clr   = '0;

    // reset state and default release order
    step(3);
    check_eq("rst ch_rst_n", 32'(bus.ch_rst_n), 32'h0);
    check_eq("rst seq_done", 32'(bus.seq_done), 32'h0);
    check_eq("rst busy", 32'(bus.busy), 32'h0);
    check_eq("rst rst_flag", 32'(bus.rst_flag), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      step(1);
      check_seq(k, r_def, 16);
    end

    // disabled channel, then late enable in DONE
    rst_n = 1'b0;
    step(2);
    bus.ch_en   = 4'b1011;
    bus.dly_cfg = '0;
    rst_n       = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step(1);
      check_seq(k, r_dis, 8);
    end
    bus.dly_cfg[16 +: 8] = 8'd2;
    bus.ch_en[2]         = 1'b1;
    step(2);
    check_eq("en2 early", 32'(bus.ch_rst_n), 32'hB);
    step(1);
    check_eq("en2 release", 32'(bus.ch_rst_n), 32'hF);

    // local reset on channel 1 with d=3
    bus.dly_cfg[8 +: 8] = 8'd3;
    bus.ch_req[1]       = 1'b1;
    step(2);
    check_eq("lreq pre-fall", 32'(bus.ch_rst_n), 32'hF);
    step(1);
    check_eq("lreq fall", 32'(bus.ch_rst_n), 32'hD);
    check_eq("lreq flag", 32'(bus.rst_flag), 32'h2);
    step(2);
    bus.ch_req[1] = 1'b0;
    step(5);
    check_eq("lreq pre-rise", 32'(bus.ch_rst_n), 32'hD);
    step(1);
    check_eq("lreq rise", 32'(bus.ch_rst_n), 32'hF);
    check_eq("flag sticky", 32'(bus.rst_flag), 32'h2);
    bus.flag_clr[1] = 1'b1;
    step(1);
    bus.flag_clr[1] = 1'b0;
    check_eq("flag clr", 32'(bus.rst_flag), 32'h0);
    bus.ch_req[1] = 1'b1;
    step(2);
    check_eq("flag pre-set", 32'(bus.rst_flag), 32'h0);
    bus.flag_clr[1] = 1'b1;
    step(1);
    bus.flag_clr[1] = 1'b0;
    check_eq("flag set wins", 32'(bus.rst_flag), 32'h2);
    bus.ch_req[1] = 1'b0;
    step(8);
    check_eq("lreq2 rise", 32'(bus.ch_rst_n), 32'hF);

    // global re-sequence at idx=2
    rst_n = 1'b0;
    step(2);
    bus.ch_en   = 4'hF;
    bus.dly_cfg = {4{8'd2}};
    rst_n       = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step(1);
      check_seq(k, r_def, 16);
    end
    bus.glb_req = 1'b1;
    step(1);
    bus.glb_req = 1'b0;
    check_eq("glb E11 ch", 32'(bus.ch_rst_n), 32'h3);
    step(1);
    check_eq("glb E12 ch", 32'(bus.ch_rst_n), 32'h3);
    step(1);
    check_eq("glb E13 ch", 32'(bus.ch_rst_n), 32'h0);
    check_eq("glb E13 seq_done", 32'(bus.seq_done), 32'h0);
    check_eq("glb E13 busy", 32'(bus.busy), 32'h1);
    for (int k = 14; k <= 30; k++) begin
      step(1);
      check_seq(k - 13, r_def, 16);
    end

    // reset while in DONE with a flag set
    bus.ch_req[0] = 1'b1;
    step(3);
    check_eq("pre-rst ch", 32'(bus.ch_rst_n), 32'hE);
    check_eq("pre-rst flag", 32'(bus.rst_flag), 32'h1);
    rst_n      = 1'b0;
    bus.ch_req = '0;
    step(1);
    check_eq("midrst ch", 32'(bus.ch_rst_n), 32'h0);
    check_eq("midrst seq_done", 32'(bus.seq_done), 32'h0);
    check_eq("midrst busy", 32'(bus.busy), 32'h0);
    check_eq("midrst flag", 32'(bus.rst_flag), 32'h0);
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      step(1);
      check_seq(k, r_def, 16);
    end

    // testmode bypass
    bus.testmode   = 1'b1;
    bus.test_rst_n = 1'b0;
    #1;
    check_eq("tm low", 32'(bus.ch_rst_n), 32'h0);
    bus.test_rst_n = 1'b1;
    #1;
    check_eq("tm high", 32'(bus.ch_rst_n), 32'hF);
    bus.test_rst_n = 1'b0;
    #1;
    check_eq("tm low2", 32'(bus.ch_rst_n), 32'h0);
    check_eq("tm seq_done", 32'(bus.seq_done), 32'h1);
    step(1);
    check_eq("tm edge ch", 32'(bus.ch_rst_n), 32'h0);
    check_eq("tm edge busy", 32'(bus.busy), 32'h0);
    bus.testmode = 1'b0;
    #1;
    check_eq("tm exit", 32'(bus.ch_rst_n), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
